fft_twiddle_sequencer: RTL and testbench

// Sequences twiddle factors for a radix-2 DIT FFT of SIZE_FFT points, one per butterfly, stage by stage.

---
 rtl/fft_twiddle_sequencer_if.sv | 40 ++++
 rtl/fft_twiddle_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_twiddle_sequencer_if.sv
// Handshake and twiddle bus between the twiddle sequencer and its consumer.
// Ports:
//   start_val / start_rdy   request a full twiddle sequence (sequencer is the target)
//   twiddle_val / _rdy      twiddle stream handshake (sequencer is the source)
//   twiddle_real / _imag    W = cos - j*sin, BIT_WIDTH signed each
//   stage_idx / bfly_idx    stage s and butterfly b of the presented twiddle
//   twiddle_last            marks the final twiddle of a run
//   done                    one-cycle pulse after the final transfer
// Modports: master = sequencer side, slave = environment/datapath side.
interface fft_twiddle_sequencer_if #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned SIZE_FFT  = 64
);
  localparam int unsigned LOG_N = $clog2(SIZE_FFT);
  localparam int unsigned SW    = $clog2(LOG_N);
  localparam int unsigned BW    = LOG_N - 1;

  logic                 start_val;
  logic                 start_rdy;
  logic                 twiddle_val;
  logic                 twiddle_rdy;
  logic [BIT_WIDTH-1:0] twiddle_real;
  logic [BIT_WIDTH-1:0] twiddle_imag;
  logic [SW-1:0]        stage_idx;
  logic [BW-1:0]        bfly_idx;
  logic                 twiddle_last;
  logic                 done;

  modport master (
    input  start_val, twiddle_rdy,
    output start_rdy, twiddle_val, twiddle_real, twiddle_imag,
           stage_idx, bfly_idx, twiddle_last, done
  );

  modport slave (
    output start_val, twiddle_rdy,
    input  start_rdy, twiddle_val, twiddle_real, twiddle_imag,
           stage_idx, bfly_idx, twiddle_last, done
  );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Twiddle-factor sequencer for a radix-2 DIT FFT: streams one twiddle per
// butterfly, stage by stage, reading cos and sin from a single sine table
// (cos taken a quarter period ahead).
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-low
//   sine_wave_in  sine table, entry i = sin(2*pi*i/N), must be static during a run
//   inverse       (TWIDDLE_CONJ_EN only) captured at start; 1 = conjugate twiddles
//   tw            fft_twiddle_sequencer_if.master handshake/twiddle bus
// Configuration: define TWIDDLE_CONJ_EN to add the 'inverse' port.
module fft_twiddle_sequencer #(
  parameter int unsigned BIT_WIDTH     = 32,
  parameter int unsigned DECIMAL_POINT = 16,
  parameter int unsigned SIZE_FFT      = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  sine_wave_in,
`ifdef TWIDDLE_CONJ_EN
  input  logic                                inverse,
`endif
  fft_twiddle_sequencer_if.master             tw
);

  localparam int unsigned LOG_N = $clog2(SIZE_FFT);
  localparam int unsigned SW    = $clog2(LOG_N);
  localparam int unsigned BW    = LOG_N - 1;

  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 1);
  localparam logic [BW-1:0]    LAST_BFLY  = BW'(SIZE_FFT / 2 - 1);
  localparam logic [LOG_N-1:0] QUARTER    = LOG_N'(SIZE_FFT / 4);

  // Elaboration-time parameter sanity (the table format itself is pass-through).
  if (DECIMAL_POINT >= BIT_WIDTH) begin : g_bad_dp
    $error("DECIMAL_POINT must be smaller than BIT_WIDTH");
  end
  if (SIZE_FFT < 4 || (SIZE_FFT & (SIZE_FFT - 1)) != 0) begin : g_bad_n
    $error("SIZE_FFT must be a power of two >= 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [BW-1:0]        bfly_q, bfly_d;
  logic                 val_q, val_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 start_rdy_q, start_rdy_d;
  logic [BIT_WIDTH-1:0] real_q, real_d;
  logic [BIT_WIDTH-1:0] imag_q, imag_d;
  logic                 load;
`ifdef TWIDDLE_CONJ_EN
  logic                 inv_q, inv_d;
`endif

  logic [LOG_N-1:0]     bfly_ext;
  logic [LOG_N-1:0]     bmask;
  logic [LOG_N-1:0]     k_c;
  logic [LOG_N-1:0]     kcos_c;
  logic [BIT_WIDTH-1:0] sin_k;

  // Next-state, counter advance and output-register load control.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    val_d   = val_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef TWIDDLE_CONJ_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tw.start_val && start_rdy_q) begin
          state_d = ST_RUN;
          stage_d = '0;
          bfly_d  = '0;
          val_d   = 1'b1;
          load    = 1'b1;
`ifdef TWIDDLE_CONJ_EN
          inv_d   = inverse;
`endif
        end
      end
      ST_RUN: begin
        if (val_q && tw.twiddle_rdy) begin
          if (last_q) begin
            state_d = ST_DONE;
            val_d   = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            if (bfly_q == LAST_BFLY) begin
              bfly_d  = '0;
              stage_d = stage_q + SW'(1);
            end else begin
              bfly_d  = bfly_q + BW'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (load) begin
      last_d = (stage_d == LAST_STAGE) && (bfly_d == LAST_BFLY);
    end
    start_rdy_d = (state_d == ST_IDLE);
  end

  // Table lookup for the twiddle being loaded: k = (b mod 2^s) << (LOG_N-1-s).
  always_comb begin
    bfly_ext = LOG_N'(bfly_d);
    bmask    = (LOG_N'(1) << stage_d) - LOG_N'(1);
    k_c      = (bfly_ext & bmask) << (LAST_STAGE - stage_d);
    kcos_c   = k_c + QUARTER;  // wraps mod N by width
    sin_k    = sine_wave_in[k_c];
    real_d   = real_q;
    imag_d   = imag_q;
    if (load) begin
      real_d = sine_wave_in[kcos_c];
`ifdef TWIDDLE_CONJ_EN
      imag_d = inv_d ? sin_k : -sin_k;
`else
      imag_d = -sin_k;
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      bfly_q      <= '0;
      val_q       <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      start_rdy_q <= 1'b1;
      real_q      <= '0;
      imag_q      <= '0;
`ifdef TWIDDLE_CONJ_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      val_q       <= val_d;
      last_q      <= last_d;
      done_q      <= done_d;
      start_rdy_q <= start_rdy_d;
      real_q      <= real_d;
      imag_q      <= imag_d;
`ifdef TWIDDLE_CONJ_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign tw.start_rdy    = start_rdy_q;
  assign tw.twiddle_val  = val_q;
  assign tw.twiddle_real = real_q;
  assign tw.twiddle_imag = imag_q;
  assign tw.stage_idx    = stage_q;
  assign tw.bfly_idx     = bfly_q;
  assign tw.twiddle_last = last_q;
  assign tw.done         = done_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Self-checking bench for fft_twiddle_sequencer (N=64, 32-bit Q16 sine table).
module tb_fft_twiddle_sequencer;
  localparam int unsigned BIT_WIDTH     = 32;
  localparam int unsigned DECIMAL_POINT = 16;
  localparam int unsigned SIZE_FFT      = 64;
  localparam int unsigned LOG_N         = $clog2(SIZE_FFT);
  localparam int unsigned TOTAL         = SIZE_FFT / 2 * LOG_N;

  logic clk = 1'b0;
  logic reset;
  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] sine_wave_in;
`ifdef TWIDDLE_CONJ_EN
  logic inverse;
`endif
  bit run_inv;

  always #5 clk = ~clk;

  fft_twiddle_sequencer_if #(.BIT_WIDTH(BIT_WIDTH), .SIZE_FFT(SIZE_FFT)) tw ();

  fft_twiddle_sequencer #(
    .BIT_WIDTH    (BIT_WIDTH),
    .DECIMAL_POINT(DECIMAL_POINT),
    .SIZE_FFT     (SIZE_FFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sine_wave_in(sine_wave_in),
`ifdef TWIDDLE_CONJ_EN
    .inverse     (inverse),
`endif
    .tw          (tw)
  );

  int errors = 0;
  int checks = 0;

  logic [BIT_WIDTH-1:0] tbl    [SIZE_FFT];
  logic [BIT_WIDTH-1:0] g_real [TOTAL];
  logic [BIT_WIDTH-1:0] g_imag [TOTAL];
  int                   g_stage[TOTAL];
  int                   g_bfly [TOTAL];
  logic [BIT_WIDTH-1:0] o_real [TOTAL];
  logic [BIT_WIDTH-1:0] o_imag [TOTAL];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncated Q16 sine table: sin(2*pi*i/N) * 2^DECIMAL_POINT.
  function automatic void load_sine();
    real pi = 3.141592653589793;
    for (int i = 0; i < int'(SIZE_FFT); i++) begin
      tbl[i] = BIT_WIDTH'($rtoi($sin(2.0 * pi * real'(i) / real'(SIZE_FFT)) * (2.0 ** DECIMAL_POINT)));
    end
  endfunction

  function automatic void load_random();
    for (int i = 0; i < int'(SIZE_FFT); i++) tbl[i] = BIT_WIDTH'($urandom);
  endfunction

  task automatic drive_table();
    for (int i = 0; i < int'(SIZE_FFT); i++) sine_wave_in[i] = tbl[i];
  endtask

  // Reference sequence straight from the twiddle definition W_k = cos - j sin.
  function automatic void build_golden(input bit inv);
    int n = 0;
    for (int s = 0; s < int'(LOG_N); s++) begin
      for (int b = 0; b < int'(SIZE_FFT / 2); b++) begin
        int k;
        k = (b % (1 << s)) * (int'(SIZE_FFT) >> (s + 1));
        g_real[n]  = tbl[(k + int'(SIZE_FFT) / 4) % int'(SIZE_FFT)];
        g_imag[n]  = inv ? tbl[k] : -tbl[k];
        g_stage[n] = s;
        g_bfly[n]  = b;
        n++;
      end
    end
  endfunction

  task automatic do_start();
    check("start_rdy_idle", 64'(tw.start_rdy), 64'd1);
    tw.start_val = 1'b1;
`ifdef TWIDDLE_CONJ_EN
    inverse = run_inv;
`endif
    @(negedge clk);
    tw.start_val = 1'b0;
  endtask

  // Stream twiddles; called on a negedge one cycle after the start handshake.
  task automatic stream(input int rdy_pct, input int stop_after, input bit poke_start);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [BIT_WIDTH-1:0] p_real, p_imag;
    logic [7:0] p_stage, p_bfly;
    logic p_last;
    p_real = '0; p_imag = '0; p_stage = '0; p_bfly = '0; p_last = 1'b0;
    while (idx < stop_after && cyc < 40 * int'(TOTAL)) begin
      check("val_in_run", 64'(tw.twiddle_val), 64'd1);
      if (stalled) begin
        check("hold_real",  64'(tw.twiddle_real), 64'(p_real));
        check("hold_imag",  64'(tw.twiddle_imag), 64'(p_imag));
        check("hold_stage", 64'(tw.stage_idx),    64'(p_stage));
        check("hold_bfly",  64'(tw.bfly_idx),     64'(p_bfly));
        check("hold_last",  64'(tw.twiddle_last), 64'(p_last));
      end
      if (poke_start) begin
        tw.start_val = 1'($urandom_range(1));
        check("start_rdy_run", 64'(tw.start_rdy), 64'd0);
      end
      tw.twiddle_rdy = ($urandom_range(99) < 32'(rdy_pct));
      if (tw.twiddle_val && tw.twiddle_rdy) begin
        check("tw_real",  64'(tw.twiddle_real), 64'(g_real[idx]));
        check("tw_imag",  64'(tw.twiddle_imag), 64'(g_imag[idx]));
        check("tw_stage", 64'(tw.stage_idx),    64'(g_stage[idx]));
        check("tw_bfly",  64'(tw.bfly_idx),     64'(g_bfly[idx]));
        check("tw_last",  64'(tw.twiddle_last), 64'(idx == int'(TOTAL) - 1));
        o_real[idx] = tw.twiddle_real;
        o_imag[idx] = tw.twiddle_imag;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = tw.twiddle_val;
      end
      p_real  = tw.twiddle_real;
      p_imag  = tw.twiddle_imag;
      p_stage = 8'(tw.stage_idx);
      p_bfly  = 8'(tw.bfly_idx);
      p_last  = tw.twiddle_last;
      @(negedge clk);
      cyc++;
    end
    tw.start_val = 1'b0;
    if (idx < stop_after) check("stream_timeout", 64'(idx), 64'(stop_after));
  endtask

  // Called on the negedge after the final transfer.
  task automatic finish_run();
    tw.twiddle_rdy = 1'b0;
    check("done_pulse",     64'(tw.done),        64'd1);
    check("val_after_last", 64'(tw.twiddle_val), 64'd0);
    check("start_rdy_done", 64'(tw.start_rdy),   64'd0);
    @(negedge clk);
    check("done_single",    64'(tw.done),        64'd0);
    check("start_rdy_back", 64'(tw.start_rdy),   64'd1);
  endtask

  initial begin
    reset = 1'b0;
    tw.start_val = 1'b0;
    tw.twiddle_rdy = 1'b0;
    run_inv = 1'b0;
`ifdef TWIDDLE_CONJ_EN
    inverse = 1'b0;
`endif
    load_sine();
    drive_table();

    // Reset values.
    #12;
    check("rst_val",   64'(tw.twiddle_val),  64'd0);
    check("rst_real",  64'(tw.twiddle_real), 64'd0);
    check("rst_imag",  64'(tw.twiddle_imag), 64'd0);
    check("rst_stage", 64'(tw.stage_idx),    64'd0);
    check("rst_bfly",  64'(tw.bfly_idx),     64'd0);
    check("rst_last",  64'(tw.twiddle_last), 64'd0);
    check("rst_done",  64'(tw.done),         64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_start_rdy", 64'(tw.start_rdy), 64'd1);

    // Full-rate forward run with the real sine table.
    build_golden(1'b0);
    do_start();
    stream(100, int'(TOTAL), 1'b0);
    finish_run();
    for (int b = 0; b < int'(SIZE_FFT / 2); b++) begin
      check("stage0_real", 64'(o_real[b]), 64'd65536);
      check("stage0_imag", 64'(o_imag[b]), 64'd0);
    end
    check("s5b1_real",  64'(o_real[161]), 64'd65220);
    check("s5b1_imag",  64'(o_imag[161]), 64'h0000_0000_FFFF_E6E9);
    check("s5b16_real", 64'(o_real[176]), 64'd0);
    check("s5b16_imag", 64'(o_imag[176]), 64'h0000_0000_FFFF_0000);
    check("s1b1_real",  64'(o_real[33]),  64'd0);
    check("s1b1_imag",  64'(o_imag[33]),  64'h0000_0000_FFFF_0000);
    check("s1b2_real",  64'(o_real[34]),  64'd65536);
    check("s1b2_imag",  64'(o_imag[34]),  64'd0);

    // Asynchronous reset after 10 transfers aborts the run.
    do_start();
    stream(100, 10, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("abort_val",   64'(tw.twiddle_val),  64'd0);
    check("abort_last",  64'(tw.twiddle_last), 64'd0);
    check("abort_done",  64'(tw.done),         64'd0);
    check("abort_real",  64'(tw.twiddle_real), 64'd0);
    check("abort_stage", 64'(tw.stage_idx),    64'd0);
    check("abort_bfly",  64'(tw.bfly_idx),     64'd0);
    tw.twiddle_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done",   64'(tw.done),        64'd0);
      check("abort_start_rdy", 64'(tw.start_rdy),   64'd1);
      check("abort_idle_val",  64'(tw.twiddle_val), 64'd0);
      @(negedge clk);
    end

    // Random stalls, stray start pulses during the run.
`ifdef TWIDDLE_CONJ_EN
    run_inv = 1'b1;
`endif
    build_golden(run_inv);
    do_start();
    stream(50, int'(TOTAL), 1'b1);
    finish_run();
`ifdef TWIDDLE_CONJ_EN
    check("conj_s5b1_imag", 64'(o_imag[161]), 64'd6423);
`endif

    // Random table contents exercise every index mapping.
    load_random();
    drive_table();
`ifdef TWIDDLE_CONJ_EN
    run_inv = 1'($urandom_range(1));
`endif
    build_golden(run_inv);
    do_start();
    stream(75, int'(TOTAL), 1'b0);
    finish_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
